// File: rtl/dmem_lsu_pkg.sv
// Shared types, constants and helpers for the data-memory load/store sequencer.
// Contents:
//   state_t     - sequencer states IDLE / RD / DATA / WR
//   F3_*        - RV32I load/store funct3 encodings
//   RMEM_*      - mem_rmem read codes ({signed, lane mask[3:0]})
//   req_t       - captured request fields kept for the duration of an access
//   f3_legal    - funct3 legality per direction
//   misaligned  - natural-alignment check for halfword/word accesses
//   rmem_code   - read code for the RD state
package dmem_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    DATA,
    WR
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [4:0] RMEM_NONE = 5'b00000;
  localparam logic [4:0] RMEM_SB0  = 5'b10001;  // signed byte, lane 0
  localparam logic [4:0] RMEM_WORD = 5'b01111;  // unsigned full word

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] wdata;
  } req_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Sub-word stores read the whole word for the merge, so they use RMEM_WORD.
  function automatic logic [4:0] rmem_code(input logic we, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic sgn;
    sgn = ~f3[2];
    if (we) return RMEM_WORD;
    case (f3[1:0])
      2'b00:   return {sgn, RMEM_SB0[3:0] << a};
      2'b01:   return {sgn, a[1] ? 4'b1100 : 4'b0011};
      default: return RMEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_if.sv
// CPU-side request/response bundle of the load/store sequencer.
// Signals:
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_we               1 = store, 0 = load
//   req_funct3           RV32I width/sign code
//   req_addr             byte address
//   req_wdata            right-aligned store data
//   resp_valid           one-cycle completion pulse, no backpressure
//   resp_rdata           extended load data (0 for stores/errors)
//   resp_err             request rejected, qualified by resp_valid
// Modports: master = CPU memory stage, slave = sequencer.
interface dmem_lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lsu_lane.sv
// Combinational lane logic for the load/store sequencer.
// Ports:
//   rd_word    in  word read from memory
//   wdata      in  right-aligned store data
//   addr_lo    in  byte address bits [1:0]
//   funct3     in  RV32I width/sign code
//   load_data  out selected lane, sign/zero-extended
//   store_word out rd_word with the target byte/half replaced by wdata
// Halfwords use addr_lo[1] only, so an unaligned halfword snaps to its half.
module dmem_lsu_lane
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = rd_word;
      F3_BU:   load_data = {24'h000000, byte_sel};
      F3_HU:   load_data = {16'h0000, half_sel};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_word = rd_word;
    case (funct3)
      F3_B: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      F3_W:    store_word = wdata;
      default: store_word = rd_word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the CPU memory stage and a word-addressed data
// memory with 1-cycle synchronous read and whole-word write.
//   Loads:   IDLE -> RD -> DATA -> IDLE, result registered leaving DATA.
//   SW:      IDLE -> WR -> IDLE, single full-word write.
//   SB/SH:   IDLE -> RD -> DATA -> IDLE, read-modify-write; the merged word is
//            written during DATA while the read word is on mem_load_data.
//   Illegal funct3 is answered from IDLE with resp_err and no memory access.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bus               dmem_lsu_ctrl_if.slave request/response bundle
//   mem_addr          word index {2'b00, addr[31:2]}, holds last value
//   mem_wmem          write mask, 4'b1111 in WR / store DATA, else 0
//   mem_rmem          read code {signed, lane mask} in RD, else 0
//   mem_store_data    word to write (0 when not writing)
//   mem_load_data     read word, valid the cycle after the address edge
// Build option: DMEM_LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word
// accesses with resp_err; otherwise low address bits are ignored.
module dmem_lsu_ctrl
  import dmem_lsu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  dmem_lsu_ctrl_if.slave     bus,
  output logic [31:0]        mem_addr,
  output logic [3:0]         mem_wmem,
  output logic [4:0]         mem_rmem,
  output logic [31:0]        mem_store_data,
  input  logic [31:0]        mem_load_data
);

  state_t      state;
  req_t        req_q;
  logic [4:0]  rmem_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] lane_load;
  logic [31:0] lane_store;
  logic        reject;

  dmem_lsu_lane u_lane (
    .rd_word    (mem_load_data),
    .wdata      (req_q.wdata),
    .addr_lo    (req_q.addr_lo),
    .funct3     (req_q.funct3),
    .load_data  (lane_load),
    .store_word (lane_store)
  );

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  assign reject = !f3_legal(bus.req_we, bus.req_funct3) ||
                  misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  assign reject = !f3_legal(bus.req_we, bus.req_funct3);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_q        <= '0;
      rmem_q       <= '0;
      mem_addr     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (reject) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              req_q    <= '{we:      bus.req_we,
                            funct3:  bus.req_funct3,
                            addr_lo: bus.req_addr[1:0],
                            wdata:   bus.req_wdata};
              mem_addr <= {2'b00, bus.req_addr[31:2]};
              rmem_q   <= rmem_code(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
              state    <= (bus.req_we && bus.req_funct3 == F3_W) ? WR : RD;
            end
          end
        end
        RD: state <= DATA;
        DATA: begin
          state        <= IDLE;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= req_q.we ? '0 : lane_load;
        end
        WR: begin
          state        <= IDLE;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobes decode straight from the state register so that reset
  // removes them asynchronously, never letting a partial RMW reach memory.
  always_comb begin
    mem_wmem       = '0;
    mem_store_data = '0;
    if (state == WR) begin
      mem_wmem       = '1;
      mem_store_data = req_q.wdata;
    end else if (state == DATA && req_q.we) begin
      mem_wmem       = '1;
      mem_store_data = lane_store;
    end
  end

  assign mem_rmem       = (state == RD) ? rmem_q : RMEM_NONE;
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: directed cases plus randomized
// requests compared against a behavioural model of the load/store rules and
// a shadow copy of memory.
module tb_dmem_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmem;
  logic [4:0]  mem_rmem;
  logic [31:0] mem_store_data;
  logic [31:0] mem_load_data;

  dmem_lsu_ctrl_if bus();

  dmem_lsu_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .mem_addr       (mem_addr),
    .mem_wmem       (mem_wmem),
    .mem_rmem       (mem_rmem),
    .mem_store_data (mem_store_data),
    .mem_load_data  (mem_load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int          n_rd = 0;
  int          n_wr = 0;
  logic [4:0]  last_rmem = '0;
  logic [31:0] last_addr = '0;

  // Data memory: 1-cycle synchronous read, full-word write.
  always @(posedge clk) begin
    mem_load_data <= mem[mem_addr[7:0]];
    if (mem_rmem != 5'd0) begin
      n_rd++;
      last_rmem = mem_rmem;
      last_addr = mem_addr;
    end
    if (mem_wmem != 4'd0) begin
      n_wr++;
      last_addr = mem_addr;
      if (mem_wmem == 4'hF) mem[mem_addr[7:0]] = mem_store_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one request; updates ref_mem for stores.
  function automatic void model(input bit we, input int unsigned f3, input int unsigned addr,
                                input logic [31:0] wd, output bit err, output logic [31:0] rd,
                                output int lat, output int nrd, output int nwr,
                                output logic [4:0] rm);
    int unsigned idx, lane, size, mask;
    logic [31:0] w, v;
    idx  = addr / 4;
    lane = addr % 4;
    size = f3 % 4;
    err  = we ? (f3 > 2) : !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    if ((size == 1 && (addr % 2) != 0) || (size == 2 && lane != 0)) err = 1;
`endif
    rd = 0; lat = 0; nrd = 0; nwr = 0; rm = 0;
    if (err) return;
    if (size == 1) lane = (lane / 2) * 2;
    if (size == 2) lane = 0;
    w = ref_mem[idx];
    if (!we) begin
      v = w >> (8 * lane);
      if (size == 0) begin
        v = v & 32'hFF;
        if (f3 < 4 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        rm = 5'(1 << lane);
      end else if (size == 1) begin
        v = v & 32'hFFFF;
        if (f3 < 4 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        rm = 5'(3 << lane);
      end else begin
        rm = 5'h0F;
      end
      if (f3 < 4 && size < 2) rm = rm | 5'h10;
      rd = v; lat = 2; nrd = 1;
    end else begin
      mask = (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
      ref_mem[idx] = (w & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
      lat = (size == 2) ? 1 : 2;
      nrd = (size == 2) ? 0 : 1;
      nwr = 1;
      rm  = 5'h0F;
    end
  endfunction

  task automatic do_req(input string nm, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] got);
    bit e_err; logic [31:0] e_rd; int e_lat, e_nrd, e_nwr; logic [4:0] e_rm;
    int rd0, wr0, lat;
    model(we, f3, addr, wd, e_err, e_rd, e_lat, e_nrd, e_nwr, e_rm);
    @(negedge clk);
    check({nm, " ready"}, bus.req_ready, 1);
    bus.req_valid = 1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    rd0 = n_rd; wr0 = n_wr;
    @(posedge clk); #1;
    bus.req_valid = 0;
    lat = 0;
    while (!bus.resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    got = bus.resp_rdata;
    check({nm, " lat"}, lat, e_lat);
    check({nm, " err"}, bus.resp_err, e_err);
    check({nm, " rdata"}, bus.resp_rdata, e_rd);
    check({nm, " nrd"}, n_rd - rd0, e_nrd);
    check({nm, " nwr"}, n_wr - wr0, e_nwr);
    if (e_nrd != 0) check({nm, " rmem"}, last_rmem, e_rm);
    if (e_nrd + e_nwr != 0) check({nm, " addr"}, last_addr, addr >> 2);
  endtask

  task automatic set_word(input int unsigned idx, input logic [31:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  logic [31:0] got;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst ready", bus.req_ready, 1);
    check("rst valid", bus.resp_valid, 0);
    check("rst err", bus.resp_err, 0);
    check("rst rdata", bus.resp_rdata, 0);
    check("rst addr", mem_addr, 0);
    check("rst wmem", mem_wmem, 0);
    check("rst rmem", mem_rmem, 0);
    check("rst sdata", mem_store_data, 0);

    set_word(32'h40, 32'h80FF_1234);
    do_req("lb", 0, 3'b000, 32'h0000_0103, 0, got);
    check("lb value", got, 32'hFFFF_FF80);
    check("lb rmem", last_rmem, 5'b11000);
    do_req("lhu", 0, 3'b101, 32'h0000_0102, 0, got);
    check("lhu value", got, 32'h0000_80FF);

    set_word(32'h40, 32'h1122_3344);
    do_req("sb", 1, 3'b000, 32'h0000_0101, 32'h0000_00AB, got);
    check("sb word", mem[32'h40], 32'h1122_AB44);

    do_req("sw", 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, got);
    do_req("lw", 0, 3'b010, 32'h0000_0010, 0, got);
    check("lw value", got, 32'hDEAD_BEEF);

    do_req("lw mis", 0, 3'b010, 32'h0000_0006, 0, got);
    do_req("ld 011", 0, 3'b011, 32'h0000_0020, 0, got);
    do_req("st 100", 1, 3'b100, 32'h0000_0020, 32'h1, got);
    do_req("sh odd", 1, 3'b001, 32'h0000_0033, 32'hCAFE_F00D, got);

    for (int n = 0; n < 300; n++) begin
      bit we;
      we = 1'($urandom);
      do_req("rnd", we, 3'($urandom_range(0, 7)), $urandom_range(0, 1023), $urandom, got);
    end

    // Reset while an SH is in its write cycle.
    set_word(32'h20, 32'h5566_7788);
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = 3'b001;
    bus.req_addr = 32'h0000_0082; bus.req_wdata = 32'h0000_1234;
    @(posedge clk); #1;
    bus.req_valid = 0;
    @(posedge clk); #1;
    check("sh data wmem", mem_wmem, 4'hF);
    #1 rst = 1'b1;
    #1;
    check("rst-rmw wmem", mem_wmem, 0);
    check("rst-rmw ready", bus.req_ready, 1);
    check("rst-rmw sdata", mem_store_data, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst-rmw word", mem[32'h20], 32'h5566_7788);
    check("rst-rmw valid", bus.resp_valid, 0);
    check("rst-rmw ready2", bus.req_ready, 1);
    do_req("post lw", 0, 3'b010, 32'h0000_0080, 0, got);

    for (int i = 0; i < 256; i++) check("mem sweep", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
